// File: rtl/tomasulo_reg_status_unit_pkg.sv
// Shared constants, types and helpers for the Tomasulo register result-status unit.
// Holds the instruction field layout, the opcode encodings and the status-table shapes.
package tomasulo_reg_status_unit_pkg;

    localparam int NUM_REGS = 5;
    localparam int NUM_RS   = 6;
    localparam int TAG_W    = 3;
    localparam int FIELD_W  = 3;
    localparam int INSTR_W  = 3 * FIELD_W;

    localparam int OP_LSB = 6;
    localparam int OP_MSB = 8;
    localparam int RD_LSB = 3;
    localparam int RD_MSB = 5;
    localparam int RS_LSB = 0;
    localparam int RS_MSB = 2;

    typedef enum logic [FIELD_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011
    } opcode_e;

    typedef logic [NUM_REGS-1:0]            busy_t;
    typedef logic [NUM_REGS-1:0][TAG_W-1:0] tags_t;

    // Tags 6..7 name no station, so issue and writeback with them must be dropped.
    function automatic logic tag_valid(input logic [TAG_W-1:0] tag);
        return tag <= TAG_W'(NUM_RS - 1);
    endfunction

endpackage

// File: rtl/tomasulo_reg_status_unit_if.sv
// Issue/writeback bus of the register result-status unit.
// master = issue logic driving instructions and events, slave = the status unit.
interface tomasulo_reg_status_unit_if;
    import tomasulo_reg_status_unit_pkg::*;

    logic [INSTR_W-1:0]        instrIn;
    logic                      issue_en;
    logic [TAG_W-1:0]          issue_tag;
    logic                      wb_en;
    logic [TAG_W-1:0]          wb_tag;
    logic [FIELD_W-1:0]        opCode;
    logic [FIELD_W-1:0]        rd;
    logic [FIELD_W-1:0]        rs;
    logic                      is_addsub;
    logic                      is_muldiv;
    logic [NUM_REGS-1:0]       rd_onehot;
    logic [NUM_REGS-1:0]       rs_onehot;
    logic                      rd_busy;
    logic [TAG_W-1:0]          rd_tag;
    logic                      rs_busy;
    logic [TAG_W-1:0]          rs_tag;
    logic [NUM_REGS-1:0]       regs_busy;
    logic [NUM_REGS*TAG_W-1:0] reg_tags;

    modport master (
        output instrIn, issue_en, issue_tag, wb_en, wb_tag,
        input  opCode, rd, rs, is_addsub, is_muldiv, rd_onehot, rs_onehot,
               rd_busy, rd_tag, rs_busy, rs_tag, regs_busy, reg_tags
    );

    modport slave (
        input  instrIn, issue_en, issue_tag, wb_en, wb_tag,
        output opCode, rd, rs, is_addsub, is_muldiv, rd_onehot, rs_onehot,
               rd_busy, rd_tag, rs_busy, rs_tag, regs_busy, reg_tags
    );

endinterface

// File: rtl/tomasulo_reg_status_unit_dec3to5_onehot.sv
// 3-to-5 one-hot decoder: select values 5..7 or a low enable yield all zeros,
// so a non-existent register can never be selected.
module dec3to5_onehot
    import tomasulo_reg_status_unit_pkg::*;
(
    input  logic [FIELD_W-1:0]  sel_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    // NOTE: every bit is assigned on every pass of the loop, so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot_o[i] = en_i && (sel_i == FIELD_W'(i));
        end
    end

endmodule

// File: rtl/tomasulo_reg_status_unit.sv
// Instruction field decode plus the register result-status table (busy bit and
// producing-station tag per register) used to pick V or Q for each source operand.
module tomasulo_reg_status_unit
    import tomasulo_reg_status_unit_pkg::*;
(
    input logic                       Clock,
    input logic                       Reset,
    tomasulo_reg_status_unit_if.slave bus
);

    logic [FIELD_W-1:0]  op_f;
    logic [FIELD_W-1:0]  rd_f;
    logic [FIELD_W-1:0]  rs_f;
    logic [NUM_REGS-1:0] rd_oh;
    logic [NUM_REGS-1:0] rs_oh;

    busy_t busy_q, busy_d;
    tags_t tag_q,  tag_d;

    assign op_f = bus.instrIn[OP_MSB:OP_LSB];
    assign rd_f = bus.instrIn[RD_MSB:RD_LSB];
    assign rs_f = bus.instrIn[RS_MSB:RS_LSB];

    dec3to5_onehot u_rd_dec (
        .sel_i    (rd_f),
        .en_i     (1'b1),
        .onehot_o (rd_oh)
    );

    dec3to5_onehot u_rs_dec (
        .sel_i    (rs_f),
        .en_i     (1'b1),
        .onehot_o (rs_oh)
    );

    always_comb begin
        bus.opCode    = op_f;
        bus.rd        = rd_f;
        bus.rs        = rs_f;
        bus.is_addsub = (op_f == OP_ADD) || (op_f == OP_SUB);
        bus.is_muldiv = (op_f == OP_MUL) || (op_f == OP_DIV);
        bus.rd_onehot = rd_oh;
        bus.rs_onehot = rs_oh;
        bus.regs_busy = busy_q;
        bus.reg_tags  = tag_q;
    end

    // Reads go through the one-hot selects, so field values 5..7 read busy=0, tag=000.
    always_comb begin
        bus.rd_busy = |(busy_q & rd_oh);
        bus.rs_busy = |(busy_q & rs_oh);
        bus.rd_tag  = '0;
        bus.rs_tag  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_oh[i]) bus.rd_tag = tag_q[i];
            if (rs_oh[i]) bus.rs_tag = tag_q[i];
        end
    end

    // Writeback is applied first so a same-edge issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.wb_en && tag_valid(bus.wb_tag) && busy_q[i] && (tag_q[i] == bus.wb_tag)) begin
                busy_d[i] = 1'b0;
            end
            if (bus.issue_en && tag_valid(bus.issue_tag) && rd_oh[i]) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = bus.issue_tag;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the table is a handful of flops, not a RAM, so it is cleared on reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: tb/tb_tomasulo_reg_status_unit.sv
// Self-checking bench for tomasulo_reg_status_unit: directed scenarios followed by
// random traffic, compared against an array-based model of the register status table.
module tb_tomasulo_reg_status_unit;
    import tomasulo_reg_status_unit_pkg::*;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    tomasulo_reg_status_unit_if bus ();

    tomasulo_reg_status_unit dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference table: one busy flag and one tag per architectural register.
    bit       m_busy [5];
    bit [2:0] m_tag  [5];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [8:0] instr,
                         input logic ie, input logic [2:0] it,
                         input logic we, input logic [2:0] wt);
        Reset         = rst;
        bus.instrIn   = instr;
        bus.issue_en  = ie;
        bus.issue_tag = it;
        bus.wb_en     = we;
        bus.wb_tag    = wt;
    endtask

    function automatic logic [4:0] onehot_ref(input int v);
        return (v < 5) ? 5'(1 << v) : 5'b00000;
    endfunction

    // Advance the model by the rules of one rising edge, then let the DUT take that edge.
    task automatic tick();
        int rdv;
        rdv = int'(bus.instrIn[5:3]);
        if (Reset) begin
            for (int r = 0; r < 5; r++) begin
                m_busy[r] = 1'b0;
                m_tag[r]  = 3'd0;
            end
        end else begin
            if (bus.wb_en && bus.wb_tag < 3'd6) begin
                for (int r = 0; r < 5; r++) begin
                    if (m_busy[r] && m_tag[r] == bus.wb_tag) m_busy[r] = 1'b0;
                end
            end
            if (bus.issue_en && bus.issue_tag < 3'd6 && rdv < 5) begin
                m_busy[rdv] = 1'b1;
                m_tag[rdv]  = bus.issue_tag;
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic check_outputs(input string ph);
        int          opv, rdv, rsv;
        logic [4:0]  busy_e;
        logic [14:0] tags_e;
        opv = int'(bus.instrIn[8:6]);
        rdv = int'(bus.instrIn[5:3]);
        rsv = int'(bus.instrIn[2:0]);
        for (int r = 0; r < 5; r++) begin
            busy_e[r]       = m_busy[r];
            tags_e[3*r +: 3] = m_tag[r];
        end
        check({ph, ":opCode"},    bus.opCode,    opv);
        check({ph, ":rd"},        bus.rd,        rdv);
        check({ph, ":rs"},        bus.rs,        rsv);
        check({ph, ":is_addsub"}, bus.is_addsub, (opv == 0 || opv == 1) ? 1 : 0);
        check({ph, ":is_muldiv"}, bus.is_muldiv, (opv == 2 || opv == 3) ? 1 : 0);
        check({ph, ":rd_onehot"}, bus.rd_onehot, onehot_ref(rdv));
        check({ph, ":rs_onehot"}, bus.rs_onehot, onehot_ref(rsv));
        check({ph, ":rd_busy"},   bus.rd_busy,   (rdv < 5) ? m_busy[rdv] : 1'b0);
        check({ph, ":rd_tag"},    bus.rd_tag,    (rdv < 5) ? m_tag[rdv]  : 3'd0);
        check({ph, ":rs_busy"},   bus.rs_busy,   (rsv < 5) ? m_busy[rsv] : 1'b0);
        check({ph, ":rs_tag"},    bus.rs_tag,    (rsv < 5) ? m_tag[rsv]  : 3'd0);
        check({ph, ":regs_busy"}, bus.regs_busy, busy_e);
        check({ph, ":reg_tags"},  bus.reg_tags,  tags_e);
    endtask

    initial begin
        logic [4:0]  busy_snap;
        logic [14:0] tags_snap;

        // Reset, then decode a MUL with rd=3, rs=1.
        drive(1'b1, 9'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        tick();
        drive(1'b0, 9'b010_011_001, 1'b0, 3'd0, 1'b0, 3'd0);
        #1;
        check_outputs("reset_decode");
        check("reset_decode:rd_onehot_const", bus.rd_onehot, 5'b01000);
        check("reset_decode:rs_onehot_const", bus.rs_onehot, 5'b00010);
        check("reset_decode:regs_busy_const", bus.regs_busy, 5'b00000);

        // Out-of-range register fields.
        drive(1'b0, 9'b000_110_111, 1'b0, 3'd0, 1'b0, 3'd0);
        #1;
        check_outputs("out_of_range");
        check("out_of_range:rd_onehot_const", bus.rd_onehot, 5'b00000);

        // Issue rd=2 to station 4, then read it back through rs.
        drive(1'b0, 9'b000_010_000, 1'b1, 3'd4, 1'b0, 3'd0);
        tick();
        check("issue:regs_busy_const", bus.regs_busy, 5'b00100);
        check("issue:tag2_const",      bus.reg_tags[8:6], 3'b100);
        drive(1'b0, 9'b001_000_010, 1'b0, 3'd0, 1'b0, 3'd0);
        #1;
        check_outputs("issue_read");
        check("issue_read:rs_busy_const", bus.rs_busy, 1'b1);
        check("issue_read:rs_tag_const",  bus.rs_tag,  3'b100);

        // Writeback broadcast: regs 1 and 3 on tag 1, reg 0 on tag 2.
        drive(1'b1, 9'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        drive(1'b0, 9'b000_001_000, 1'b1, 3'd1, 1'b0, 3'd0);
        tick();
        drive(1'b0, 9'b000_011_000, 1'b1, 3'd1, 1'b0, 3'd0);
        tick();
        drive(1'b0, 9'b000_000_000, 1'b1, 3'd2, 1'b0, 3'd0);
        tick();
        check_outputs("wb_setup");
        drive(1'b0, 9'b000_001_011, 1'b0, 3'd0, 1'b1, 3'd1);
        tick();
        check_outputs("wb_broadcast");
        check("wb_broadcast:regs_busy_const", bus.regs_busy, 5'b00001);

        // Same edge: writeback of tag 4 and a new issue to reg 2 (which holds tag 4).
        drive(1'b0, 9'b000_010_000, 1'b1, 3'd4, 1'b0, 3'd0);
        tick();
        drive(1'b0, 9'b000_010_000, 1'b1, 3'd0, 1'b1, 3'd4);
        tick();
        check_outputs("same_edge");
        check("same_edge:busy2_const", bus.regs_busy[2], 1'b1);
        check("same_edge:tag2_const",  bus.reg_tags[8:6], 3'b000);

        // Ignored inputs leave the table untouched.
        busy_snap = bus.regs_busy;
        tags_snap = bus.reg_tags;
        drive(1'b0, 9'b000_001_000, 1'b1, 3'd7, 1'b0, 3'd0);
        tick();
        check("ignore_tag7:regs_busy", bus.regs_busy, busy_snap);
        check("ignore_tag7:reg_tags",  bus.reg_tags,  tags_snap);
        drive(1'b0, 9'b000_110_000, 1'b1, 3'd3, 1'b0, 3'd0);
        tick();
        check("ignore_rd6:regs_busy", bus.regs_busy, busy_snap);
        check("ignore_rd6:reg_tags",  bus.reg_tags,  tags_snap);
        drive(1'b0, 9'b000_000_000, 1'b0, 3'd0, 1'b1, 3'd7);
        tick();
        check_outputs("ignore_wb7");

        // Three registers busy, then reset with an issue on the same edge.
        drive(1'b0, 9'b000_100_000, 1'b1, 3'd5, 1'b0, 3'd0);
        tick();
        check("pre_reset:regs_busy_const", bus.regs_busy, 5'b10101);
        drive(1'b1, 9'b000_001_000, 1'b1, 3'd2, 1'b0, 3'd0);
        tick();
        check_outputs("mid_reset");
        check("mid_reset:regs_busy_const", bus.regs_busy, 5'b00000);

        // Random traffic, including WAW overwrites and occasional resets.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                  9'($urandom_range(0, 511)),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) != 0) ? 1'b1 : 1'b0,
                  3'($urandom_range(0, 7)));
            #1;
            check_outputs("rand_pre");
            tick();
        end
        drive(1'b0, 9'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        #1;
        check_outputs("rand_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tomasulo_reg_status_unit.md
Name: tomasulo_reg_status_unit

Overview:
Front-end bookkeeping block for the Tomasulo reservation-station issue path. It decodes a 9-bit instruction into opcode and register fields, and one-hot-decodes the two 3-bit register fields into 5-bit register selects. It also keeps the register result-status table: a per-register busy bit plus the producing reservation-station tag. The issue logic uses it to decide whether each source operand is a value (V) or a tag (Q).

Parameters:
NUM_REGS, 5, architectural registers tracked (one-hot decode width)
NUM_RS, 6, reservation stations (tags 0-2 add/sub, 3-5 mul/div)
TAG_W, 3, station tag width
FIELD_W, 3, opcode/register field width

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
instrIn  in  9  instruction: [8:6] opcode, [5:3] rd, [2:0] rs
issue_en  in  1  reserve rd for issue_tag this cycle
issue_tag  in  3  issuing station index 0..5
wb_en  in  1  a station broadcasts its result this cycle
wb_tag  in  3  broadcasting station index
opCode  out  3  instrIn[8:6]
rd  out  3  instrIn[5:3]
rs  out  3  instrIn[2:0]
is_addsub  out  1  opCode is ADD (000) or SUB (001)
is_muldiv  out  1  opCode is MUL (010) or DIV (011)
rd_onehot  out  5  one-hot decode of rd
rs_onehot  out  5  one-hot decode of rs
rd_busy  out  1  status busy bit of rd
rd_tag  out  3  status tag of rd
rs_busy  out  1  status busy bit of rs
rs_tag  out  3  status tag of rs
regs_busy  out  5  busy bit per register
reg_tags  out  15  tag per register; reg i at [3i+2:3i]

Behaviour:
- Decode is purely combinational: field slices, is_addsub and is_muldiv.
- Opcodes 100-111: both is_addsub and is_muldiv are 0.
- One-hot decode: value v in 0..4 sets bit v only. Values 5..7 give 00000.
- rd_busy, rd_tag, rs_busy and rs_tag are combinational reads of the current registered table, before this cycle's update.
- A field value of 5..7 reads busy=0, tag=000.
- Status table: busy[4:0] and tag[4:0][2:0] are registers updated on the rising edge of Clock.
- Reset: all busy bits = 0 and all tags = 000. Reset has priority over all other updates.
- Reset mid-operation discards every reservation in the next cycle.
- Writeback: if wb_en and wb_tag ≤ 5, every register with busy=1 and tag==wb_tag gets busy cleared to 0. The tag field keeps its value.
- Issue: if issue_en, issue_tag ≤ 5 and rd ≤ 4, then busy[rd] is set to 1 and tag[rd] is set to issue_tag.
- Issue is ignored when issue_en=0, when rd is 5..7, or when issue_tag is 6..7.
- Same-edge writeback and issue on the same register: the issue wins (busy=1, new tag).
- Writeback still clears other matching registers on that edge.
- An issue that overwrites a busy register replaces the tag (last writer wins, WAW rename).
- wb_tag 6..7: no effect.
- Latency: table outputs reflect an issue or writeback one cycle after the edge. Decode outputs have zero-cycle latency.
- No handshake. The caller guarantees issue_en is asserted only when the target station class is not full.

Decomposition:
- Shared package: opcode constants ADD=3'b000, SUB=3'b001, MUL=3'b010, DIV=3'b011.
- Shared package: NUM_REGS, NUM_RS, TAG_W, and the instruction field bit positions.
- One natural sub-module: dec3to5_onehot (3-bit input, enable, 5-bit one-hot output; enable=0 or input >4 gives 0). Instantiate it twice, for rd and rs.
- The status table stays inline.

Test Plan:
- Reset and decode: assert Reset one cycle, then instrIn=9'b010_011_001. Expect opCode=010, rd=011, rs=001, is_muldiv=1, is_addsub=0, rd_onehot=01000, rs_onehot=00010, regs_busy=00000.
- Out-of-range fields: instrIn=9'b000_110_111. Expect rd_onehot=00000, rs_onehot=00000, rd_busy=0.
- Issue: rd=2, issue_en=1, issue_tag=4. Expect regs_busy=00100 and reg_tags[8:6]=100 after the edge. Next cycle with rs=2: rs_busy=1, rs_tag=100.
- Writeback broadcast: regs 1 and 3 both tagged 001 and busy, reg 0 tagged 010. Apply wb_en=1, wb_tag=1. Expect regs_busy=00001 after the edge.
- Simultaneous events: reg 2 busy with tag 4; same edge wb_tag=4 and issue rd=2, issue_tag=0. Expect busy[2]=1, tag=000.
- Ignored inputs and mid-operation reset: issue_tag=7 or rd=6 leaves the table unchanged. Reset asserted while 3 regs are busy gives regs_busy=00000 next cycle, even if issue_en=1 on that edge.
